// File: rtl/uart_cmd_resp.sv
// uart_cmd_resp: assembles 3-byte UART commands and returns one response byte per command.
// Define UART_CMD_TIMEOUT_EN to drop partial commands after TIMEOUT_CLKS idle clocks between bytes.
module uart_cmd_resp #(
  parameter logic [19:0] TIMEOUT_CLKS = 20'd1000000,
  parameter logic [7:0]  NAK_BYTE     = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        cmd_timeout
);
  typedef enum logic [2:0] {IDLE, BYTE2, BYTE3, CMD_VALID, XMIT} state_t;
  state_t state, state_nxt;
  logic rcv, take, op_ok, tx_rise, tmo, tx_done_q;
  assign rcv = state == IDLE || state == BYTE2 || state == BYTE3;
  // clr_rdy high means the UART has not yet dropped rdy for the byte just taken
  assign take = rcv && rdy && !clr_rdy;
  assign op_ok = cmd[23:16] >= 8'h01 && cmd[23:16] <= 8'h09;
  assign tx_rise = tx_done && !tx_done_q;
`ifdef UART_CMD_TIMEOUT_EN
  logic [19:0] cnt;
  logic        in_wait;
  assign in_wait = state == BYTE2 || state == BYTE3;
  assign tmo = in_wait && !rdy && cnt == TIMEOUT_CLKS - 20'd1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      cmd_timeout <= 1'b0;
    end else begin
      cnt <= (!in_wait || take || tmo) ? '0 : !rdy ? cnt + 20'd1 : cnt;
      cmd_timeout <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign cmd_timeout = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = take ? BYTE2 : IDLE;
      BYTE2:     state_nxt = tmo ? IDLE : take ? BYTE3 : BYTE2;
      BYTE3:     state_nxt = tmo ? IDLE : take ? (op_ok ? CMD_VALID : XMIT) : BYTE3;
      CMD_VALID: state_nxt = send_resp ? XMIT : CMD_VALID;
      XMIT:      state_nxt = tx_rise ? IDLE : XMIT;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cmd <= '0;
      tx_data <= '0;
      cmd_rdy <= 1'b0;
      clr_rdy <= 1'b0;
      trmt <= 1'b0;
      resp_sent <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      clr_rdy <= take;
      if (take && state == IDLE) cmd[23:16] <= rx_data;
      if (take && state == BYTE2) cmd[15:8] <= rx_data;
      if (take && state == BYTE3) cmd[7:0] <= rx_data;
      cmd_rdy <= state_nxt == CMD_VALID;
      trmt <= state != XMIT && state_nxt == XMIT;
      if (state != XMIT && state_nxt == XMIT) tx_data <= state == CMD_VALID ? resp_data : NAK_BYTE;
      resp_sent <= state == XMIT && state_nxt == IDLE;
    end
endmodule
